pipe_adder_cla: RTL and testbench



---
 rtl/pipe_adder_cla_if.sv | 37 +++
 rtl/pipe_adder_cla.sv | 134 +++++++++++++
 tb/tb_pipe_adder_cla.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_cla_if.sv
// Operand/result handshake bundle for pipe_adder_cla.
// PIPE_ADDER_OVF_EN adds the registered signed-overflow flag ovf.
interface pipe_adder_cla_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipe_adder_cla.sv
// Pipelined add/subtract: one SEG_W-bit carry-lookahead segment per stage, carry registered between stages.
// Optional macro PIPE_ADDER_OVF_EN adds a registered signed-overflow output.
module pipe_adder_cla #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_adder_cla_if.slave   bus
);
  localparam int NSEG = WIDTH / SEG_W;
  localparam int NGRP = SEG_W / 4;

  logic adv;

  // Returns {carry_out, sum} of one segment built from 4-bit lookahead groups.
  function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] x,
                                              input logic [SEG_W-1:0] y,
                                              input logic             ci);
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W:0]   c;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;
    logic [NGRP:0]    gc;
    p  = x ^ y;
    g  = x & y;
    c  = '0;
    gc = '0;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[j*4 +: 4];
      gg[j] = g[j*4+3]
            | (p[j*4+3] & g[j*4+2])
            | (p[j*4+3] & p[j*4+2] & g[j*4+1])
            | (p[j*4+3] & p[j*4+2] & p[j*4+1] & g[j*4]);
    end
    gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < NGRP; j++) begin
      c[j*4] = gc[j];
      for (int i = 1; i < 4; i++) begin
        c[j*4+i] = g[j*4+i-1] | (p[j*4+i-1] & c[j*4+i-1]);
      end
    end
    c[SEG_W] = gc[NGRP];
    return {c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : stage
      localparam int OPW = WIDTH - gi*SEG_W;

      logic [OPW-1:0]            op_a;
      logic [OPW-1:0]            op_b;
      logic                      c_in;
      logic                      v_in;
      logic [SEG_W:0]            seg;
      logic [(gi+1)*SEG_W-1:0]   res_next;
      logic                      valid_reg;
      logic                      carry_reg;
      logic [(gi+1)*SEG_W-1:0]   res_reg;

      if (gi == 0) begin : head
        // b is inverted here so later stages only ever add.
        assign op_a     = bus.a;
        assign op_b     = bus.b ^ {WIDTH{bus.sub}};
        assign c_in     = bus.sub | bus.cin;
        assign v_in     = bus.in_valid;
        assign res_next = seg[SEG_W-1:0];
      end else begin : body
        assign op_a     = stage[gi-1].fwd.opa_reg;
        assign op_b     = stage[gi-1].fwd.opb_reg;
        assign c_in     = stage[gi-1].carry_reg;
        assign v_in     = stage[gi-1].valid_reg;
        assign res_next = {seg[SEG_W-1:0], stage[gi-1].res_reg};
      end

      assign seg = cla_seg(op_a[SEG_W-1:0], op_b[SEG_W-1:0], c_in);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          res_reg   <= '0;
        end else if (adv) begin
          valid_reg <= v_in;
          carry_reg <= seg[SEG_W];
          res_reg   <= res_next;
        end
      end

      // Upper operand bits travel with their carry to the next stage.
      if (gi < NSEG-1) begin : fwd
        logic [OPW-SEG_W-1:0] opa_reg;
        logic [OPW-SEG_W-1:0] opb_reg;
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            opa_reg <= '0;
            opb_reg <= '0;
          end else if (adv) begin
            opa_reg <= op_a[OPW-1:SEG_W];
            opb_reg <= op_b[OPW-1:SEG_W];
          end
        end
      end

`ifdef PIPE_ADDER_OVF_EN
      if (gi == NSEG-1) begin : last
        logic ovf_reg;
        // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (adv) begin
            ovf_reg <= op_a[SEG_W-1] ^ op_b[SEG_W-1] ^ seg[SEG_W-1] ^ seg[SEG_W];
          end
        end
      end
`endif
    end
  endgenerate

  assign adv           = ~stage[NSEG-1].valid_reg | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = stage[NSEG-1].valid_reg;
  assign bus.sum       = stage[NSEG-1].res_reg;
  assign bus.cout      = stage[NSEG-1].carry_reg;
`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf       = stage[NSEG-1].last.ovf_reg;
`endif

endmodule

// File: tb/tb_pipe_adder_cla.sv
// Directed + random scoreboard bench for pipe_adder_cla (WIDTH=32, SEG_W=16).
// Checks ovf as well when PIPE_ADDER_OVF_EN is defined.
module tb_pipe_adder_cla;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_adder_cla_if #(.WIDTH(32)) bus();

  pipe_adder_cla #(.WIDTH(32), .SEG_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  res_t q[$];
  res_t pend;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   pops   = 0;
  int   first_pop = -1;
  int   last_pop  = -1;
  bit   accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] t;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (a[31] == bb[31]) && (t[31] != a[31]);
    return r;
  endfunction

  // Scoreboard bookkeeping at the falling edge, then advance one clock.
  task automatic tick();
    res_t e;
    @(negedge clk);
    accepted = 0;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(pend);
        accepted = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 64'(bus.sum), 64'hDEAD);
        end else begin
          e = q.pop_front();
          $display("txn cyc=%0d sum=%h cout=%b exp_sum=%h exp_cout=%b", cyc, bus.sum, bus.cout, e.sum, e.cout);
          check("sum", 64'(bus.sum), 64'(e.sum));
          check("cout", 64'(bus.cout), 64'(e.cout));
`ifdef PIPE_ADDER_OVF_EN
          check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input res_t e);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    pend = e;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, held_sum;
    logic        rc, rs, held_cout;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Cross-segment carry with latency check
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, res_t'{ovf: 1'b0, cout: 1'b0, sum: 32'h00010000});
    check("lat_t1_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("lat_t2_out_valid", 64'(bus.out_valid), 64'd1);
    drain();

    // Full wrap, subtracts (cin ignored in subtract mode)
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, res_t'{ovf: 1'b0, cout: 1'b1, sum: 32'h00000000});
    issue(32'd5, 32'd7, 1'b0, 1'b1, res_t'{ovf: 1'b0, cout: 1'b0, sum: 32'hFFFFFFFE});
    issue(32'h80000000, 32'd1, 1'b0, 1'b1, res_t'{ovf: 1'b1, cout: 1'b1, sum: 32'h7FFFFFFF});
    issue(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, res_t'{ovf: 1'b1, cout: 1'b0, sum: 32'h80000000});
    issue(32'd9, 32'd4, 1'b1, 1'b1, res_t'{ovf: 1'b0, cout: 1'b1, sum: 32'd5});
    drain();

    // Back-to-back streaming
    pops = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    drain();
    check("stream_pops", 64'(pops), 64'd8);
    check("stream_contiguous", 64'(last_pop - first_pop), 64'd7);

    // Back-pressure with a full pipe and a third operation waiting
    bus.out_ready = 1'b0;
    issue(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, model(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0));
    issue(32'h00000003, 32'h00000010, 1'b0, 1'b1, model(32'h00000003, 32'h00000010, 1'b0, 1'b1));
    check("bp_full_out_valid", 64'(bus.out_valid), 64'd1);
    held_sum  = bus.sum;
    held_cout = bus.cout;
    bus.a = 32'hAAAA5555; bus.b = 32'h5555AAAB; bus.cin = 1'b0; bus.sub = 1'b0;
    pend = model(32'hAAAA5555, 32'h5555AAAB, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_sum_hold", 64'(bus.sum), 64'(held_sum));
      check("bp_cout_hold", 64'(bus.cout), 64'(held_cout));
    end
    check("bp_queue_depth", 64'(q.size()), 64'd2);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_extra", 64'(bus.out_valid), 64'd0);
    end

    // Reset mid-flight
    issue(32'h00000011, 32'h00000022, 1'b0, 1'b0, model(32'h11, 32'h22, 1'b0, 1'b0));
    issue(32'h00000033, 32'h00000044, 1'b0, 1'b0, model(32'h33, 32'h44, 1'b0, 1'b0));
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_sum", 64'(bus.sum), 64'd0);
    q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
